// File: rtl/y86_pkg.sv
// Y86 instruction encoding shared by the loader and the fetch/decode stage.
// Keeps instruction-length decoding in one place so valP and loader packing agree.
package y86_pkg;

  localparam int INST_W = 80;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Instruction length in bytes; 0 marks an invalid icode.
  function automatic logic [3:0] icode_len(input logic [3:0] icode);
    case (icode)
      I_HALT, I_NOP, I_RET:               return 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:   return 4'd2;
      I_JXX, I_CALL:                      return 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:       return 4'd10;
      default:                            return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/inst_len.sv
// Combinational icode -> {length, valid} decoder; zero latency, no handshake.
module inst_len
  import y86_pkg::*;
(
  input  logic [3:0] i_icode,
  output logic [3:0] o_len,
  output logic       o_vld
);

  logic [3:0] w_len;

  assign w_len = icode_len(i_icode);
  assign o_len = w_len;
  assign o_vld = (w_len != 4'd0);

endmodule

// File: rtl/inst_loader.sv
// Fills the instruction store from a byte stream: one left-aligned 80-bit write per instruction.
// Write issues the cycle after the last byte; in_ready drops during the write, after done, and after error.
module inst_loader
  import y86_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [INST_W-1:0] wr_data,
  output logic [AW-1:0]     count,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_OP    = 3'd0,
    S_BODY  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [AW-1:0] LP_LAST = AW'(DEPTH - 1);

  state_t              r_state;
  logic [3:0]          r_remaining;
  logic [3:0]          r_idx;
  logic [3:0]          r_icode;
  logic [INST_W-1:0]   r_word;
  logic                r_wr_en;
  logic [AW-1:0]       r_wr_addr;
  logic [INST_W-1:0]   r_wr_data;
  logic [AW-1:0]       r_count;

  state_t              w_state_nxt;
  logic [3:0]          w_remaining_nxt;
  logic [3:0]          w_idx_nxt;
  logic [3:0]          w_icode_nxt;
  logic [INST_W-1:0]   w_word_nxt;
  logic                w_in_ready;
  logic                w_accept;
  logic [3:0]          w_len;
  logic                w_len_vld;
  logic [6:0]          w_shamt;

  inst_len u_inst_len (
    .i_icode (in_byte[7:4]),
    .o_len   (w_len),
    .o_vld   (w_len_vld)
  );

  assign w_in_ready = (r_state == S_OP) || (r_state == S_BODY);
  assign w_accept   = in_valid && w_in_ready;
  assign w_shamt    = {r_idx, 3'b000};

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_idx_nxt       = r_idx;
    w_icode_nxt     = r_icode;
    w_word_nxt      = r_word;
    case (r_state)
      S_OP: begin
        if (w_accept) begin
          if (!w_len_vld) begin
            w_state_nxt = S_ERR;
          end else begin
            // A new opcode starts from a clean word so short instructions pad with zeros.
            w_word_nxt      = {in_byte, 72'h0};
            w_icode_nxt     = in_byte[7:4];
            w_idx_nxt       = 4'd1;
            w_remaining_nxt = w_len - 4'd1;
            w_state_nxt     = (w_len == 4'd1) ? S_WRITE : S_BODY;
          end
        end
      end
      S_BODY: begin
        if (w_accept) begin
          w_word_nxt      = r_word | ({in_byte, 72'h0} >> w_shamt);
          w_idx_nxt       = r_idx + 4'd1;
          w_remaining_nxt = r_remaining - 4'd1;
          if (r_remaining == 4'd1) begin
            w_state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if ((r_icode == I_HALT) || (r_count == LP_LAST)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_OP;
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_OP;
      r_remaining <= 4'd0;
      r_idx       <= 4'd0;
      r_icode     <= 4'd0;
      r_word      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_idx       <= w_idx_nxt;
      r_icode     <= w_icode_nxt;
      r_word      <= w_word_nxt;
      // Write outputs load on entry to S_WRITE so the strobe lands the cycle after the last byte.
      r_wr_en     <= (w_state_nxt == S_WRITE);
      if (w_state_nxt == S_WRITE) begin
        r_wr_addr <= r_count;
        r_wr_data <= w_word_nxt;
      end
      if (r_state == S_WRITE) begin
        r_count <= r_count + AW'(1);
      end
    end
  end

  assign in_ready = w_in_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign count    = r_count;
  assign done     = (r_state == S_DONE);
  assign error    = (r_state == S_ERR);

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader with a byte-stream reference model of the instruction store writes.
module tb_inst_loader;

  localparam int DEPTH = 10;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [79:0]   wr_data;
  logic [AW-1:0] count;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  inst_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_byte  (in_byte),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .count    (count),
    .done     (done),
    .error    (error)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int ref_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 0;
    endcase
  endfunction

  // Reference model: accepted bytes accumulate until the opcode's length is reached.
  logic [7:0]  m_buf[$];
  int          m_cnt = 0;
  bit          m_done = 0, m_err = 0, m_pend = 0;
  logic [79:0] m_word = '0;
  logic [79:0] m_last_data = '0;
  int          m_last_addr = 0;
  logic [79:0] wr_log[DEPTH];
  int          wr_log_n = 0;
  bit          mon_en = 0;

  always @(negedge clk) begin : mon
    bit ready_m;
    int len;
    if (mon_en) begin
      ready_m = !(m_done || m_err || m_pend);
      chk("wr_en", 80'(wr_en), 80'(m_pend));
      if (m_pend) begin
        chk("wr_addr", 80'(wr_addr), 80'(m_cnt - 1));
        chk("wr_data", wr_data, m_word);
        m_last_data = m_word;
        m_last_addr = m_cnt - 1;
        if (wr_log_n < DEPTH) begin
          wr_log[wr_log_n] = wr_data;
          wr_log_n++;
        end
      end else begin
        chk("wr_data_hold", wr_data, m_last_data);
        chk("wr_addr_hold", 80'(wr_addr), 80'(m_last_addr));
      end
      chk("count", 80'(count), 80'(m_cnt - int'(m_pend)));
      chk("done", 80'(done), 80'(m_done && !m_pend));
      chk("error", 80'(error), 80'(m_err));
      chk("in_ready", 80'(in_ready), 80'(ready_m));

      if (rst) begin
        m_buf.delete();
        m_cnt = 0; m_done = 0; m_err = 0; m_pend = 0;
        m_last_data = '0; m_last_addr = 0; wr_log_n = 0;
      end else begin
        m_pend = 0;
        if (in_valid && ready_m) begin
          m_buf.push_back(in_byte);
          len = ref_len(m_buf[0][7:4]);
          if (len == 0) begin
            m_err = 1;
            m_buf.delete();
          end else if (m_buf.size() == len) begin
            m_word = '0;
            for (int k = 0; k < len; k++) m_word[79 - 8*k -: 8] = m_buf[k];
            m_pend = 1;
            m_cnt++;
            if (m_buf[0][7:4] == 4'h0 || m_cnt == DEPTH) m_done = 1;
            m_buf.delete();
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap_pct);
    bit acc;
    int t;
    acc = 0;
    t = 0;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      in_valid = 1'b0;
      in_byte = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_byte = b;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = in_ready && !rst;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    chk("send_acc", 80'(acc), 80'(1));
  endtask

  task automatic offer(input logic [7:0] b, input int n);
    in_valid = 1'b1;
    in_byte = b;
    repeat (n) @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [7:0] cb[9];
  logic [3:0] ic;
  int gap;

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;
    do_reset();

    // Short program ending in halt
    send(8'h10, 0); send(8'h60, 0); send(8'h23, 0); send(8'h00, 0);
    idle(4);
    chk("t1_slot0", wr_log[0], {8'h10, 72'h0});
    chk("t1_slot1", wr_log[1], {16'h6023, 64'h0});
    chk("t1_slot2", wr_log[2], 80'h0);
    chk("t1_nwr", 80'(wr_log_n), 80'(3));
    chk("t1_count", 80'(count), 80'(3));
    chk("t1_done", 80'(done), 80'(1));

    // Full-length irmovq
    do_reset();
    send(8'h30, 0); send(8'hF2, 0);
    for (int k = 1; k <= 8; k++) send(8'(k), 0);
    idle(3);
    chk("t2_slot0", wr_log[0], 80'h30F20102030405060708);
    chk("t2_nwr", 80'(wr_log_n), 80'(1));
    chk("t2_count", 80'(count), 80'(1));

    // Invalid opcode: sticky error, later bytes held off
    do_reset();
    send(8'hC0, 0);
    offer(8'h10, 6);
    chk("t3_error", 80'(error), 80'(1));
    chk("t3_ready", 80'(in_ready), 80'(0));
    chk("t3_nwr", 80'(wr_log_n), 80'(0));
    chk("t3_count", 80'(count), 80'(0));

    // Store fills to DEPTH without a halt
    do_reset();
    for (int i = 0; i < DEPTH; i++) send(8'h10, 0);
    offer(8'h10, 6);
    chk("t4_count", 80'(count), 80'(DEPTH));
    chk("t4_done", 80'(done), 80'(1));
    chk("t4_nwr", 80'(wr_log_n), 80'(DEPTH));
    chk("t4_slot9", wr_log[DEPTH-1], {8'h10, 72'h0});

    // call with random valid gaps
    do_reset();
    cb[0] = 8'h80;
    for (int k = 1; k < 9; k++) cb[k] = 8'($urandom);
    for (int k = 0; k < 9; k++) send(cb[k], 50);
    idle(3);
    chk("t5_slot0", wr_log[0], {cb[0], cb[1], cb[2], cb[3], cb[4], cb[5], cb[6], cb[7], cb[8], 8'h00});
    chk("t5_nwr", 80'(wr_log_n), 80'(1));

    // Reset mid-instruction
    do_reset();
    send(8'h30, 0); send(8'hF2, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    do_reset();
    chk("t6_wr_en", 80'(wr_en), 80'(0));
    chk("t6_wr_addr", 80'(wr_addr), 80'(0));
    chk("t6_wr_data", wr_data, 80'h0);
    chk("t6_count", 80'(count), 80'(0));
    chk("t6_done", 80'(done), 80'(0));
    chk("t6_error", 80'(error), 80'(0));
    chk("t6_ready", 80'(in_ready), 80'(1));
    chk("t6_nwr0", 80'(wr_log_n), 80'(0));
    send(8'h10, 0);
    idle(3);
    chk("t6_nwr1", 80'(wr_log_n), 80'(1));
    chk("t6_slot0", wr_log[0], {8'h10, 72'h0});

    // Random programs
    for (int r = 0; r < 8; r++) begin
      do_reset();
      gap = $urandom_range(0, 40);
      for (int i = 0; i < 16; i++) begin
        if (m_done || m_err) break;
        if ($urandom_range(0, 99) < 5)       ic = 4'($urandom_range(12, 15));
        else if ($urandom_range(0, 99) < 5)  ic = 4'h0;
        else                                 ic = 4'($urandom_range(1, 11));
        send({ic, 4'($urandom)}, gap);
        for (int k = 1; k < ref_len(ic); k++) send(8'($urandom), gap);
      end
      idle(4);
      chk("rnd_nwr", 80'(wr_log_n), 80'(m_cnt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
